// File: rtl/cacheline_adaptor.sv
// Cache-line to memory-burst adaptor.
// Bridges the cache's single-shot LINE_W transfer (read_i/write_i/resp_o) onto a
// BEATS-beat BURST_W burst interface (read_o/write_o/resp_i). Fills are assembled
// beat by beat into line_o; writebacks are serialised from a private line copy.
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  // LINE_W is expected to be an integer multiple of BURST_W.
  localparam int BEATS  = LINE_W / BURST_W;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFS_W = $clog2(LINE_W / 8);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [LINE_W-1:0] wbuf;
  logic [ADDR_W-1:0] addr_aligned;
  logic              beat_last;
  logic              addr_unused;

  // Byte offset within the line never reaches memory; bursts are line aligned.
  assign addr_aligned = {address_i[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
  assign addr_unused  = ^address_i[OFFS_W-1:0];
  assign beat_last    = (cnt == LAST_BEAT);

  // Control: transaction state and beat counter. The counter only returns to
  // zero through the last-beat rule, never by free-running wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i)     state <= WR;
          else if (read_i) state <= RD;
        end
        RD, WR: begin
          if (resp_i) begin
            if (beat_last) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        // A request still held here is not re-accepted; IDLE samples it next.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Cache-visible data: latched burst address and the assembled fill line.
  always_ff @(posedge clk) begin
    if (rst) begin
      address_o <= '0;
      line_o    <= '0;
    end else begin
      if (state == IDLE && (write_i || read_i))
        address_o <= addr_aligned;
      if (state == RD && resp_i)
        line_o[BURST_W*cnt +: BURST_W] <= burst_i;
    end
  end

  // Private writeback copy so the cache may reuse line_i once accepted.
  always_ff @(posedge clk) begin
    if (state == IDLE && write_i)
      wbuf <= line_i;
  end

  // Moore decode of the handshake outputs and the current write beat.
  always_comb begin
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    burst_o = '0;
    case (state)
      RD:   read_o = 1'b1;
      WR: begin
        write_o = 1'b1;
        burst_o = wbuf[BURST_W*cnt +: BURST_W];
      end
      DONE: resp_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: stimulus tasks push expected
// requests, write beats and line responses; a negedge monitor pops and compares.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
  } req_t;

  typedef struct {
    logic         is_wr;
    logic [255:0] line;
  } rsp_t;

  req_t        exp_req[$];
  rsp_t        exp_rsp[$];
  logic [63:0] exp_wbeat[$];

  int total = 0;
  int bad = 0;
  int resp_cnt = 0;
  int exp_pulses = 0;

  cacheline_adaptor #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s: got unexpected DUT event want none", name);
  endtask

  // Monitor: compares whenever the DUT presents a request, a write beat or a response.
  initial begin
    logic prev_req;
    req_t r;
    rsp_t s;
    logic [63:0] wb;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if ((read_o || write_o) && !prev_req) begin
          if (exp_req.size() == 0) miss("req_unexp");
          else begin
            r = exp_req.pop_front();
            chk("req_kind", write_o, r.is_wr);
            chk("req_addr", address_o, r.addr);
            chk("req_excl", read_o & write_o, 1'b0);
          end
        end
        if (write_o && resp_i) begin
          if (exp_wbeat.size() == 0) miss("wbeat_unexp");
          else begin
            wb = exp_wbeat.pop_front();
            chk("wbeat", burst_o, wb);
          end
        end
        if (resp_o) begin
          resp_cnt++;
          if (exp_rsp.size() == 0) miss("resp_unexp");
          else begin
            s = exp_rsp.pop_front();
            if (!s.is_wr) chk("fill_line", line_o, s.line);
          end
        end
      end
      prev_req = read_o | write_o;
    end
  end

  task automatic do_accept(input bit is_wr, input bit both, input logic [31:0] addr,
                           input logic [31:0] exp_addr, input logic [255:0] line);
    req_t r;
    r.is_wr = is_wr;
    r.addr  = exp_addr;
    exp_req.push_back(r);
    address_i = addr;
    if (is_wr) begin
      line_i  = line;
      write_i = 1'b1;
      read_i  = both;
    end else begin
      read_i = 1'b1;
    end
    @(posedge clk); #1;
    if (is_wr) line_i = '0;
  endtask

  // pat is the per-cycle resp_i sequence, bit 0 first; it must hold exactly four ones.
  task automatic do_beats(input bit is_wr, input logic [255:0] line,
                          input logic [7:0] pat, input int npat);
    rsp_t s;
    int nb;
    s.is_wr = is_wr;
    s.line  = line;
    exp_rsp.push_back(s);
    exp_pulses++;
    if (is_wr)
      for (int k = 0; k < 4; k++) exp_wbeat.push_back(line[64*k +: 64]);
    nb = 0;
    for (int i = 0; i < npat; i++) begin
      resp_i  = pat[i];
      burst_i = (pat[i] && !is_wr) ? line[64*nb +: 64] : 64'hDEAD_BEEF_0BAD_F00D;
      @(negedge clk);
      if (is_wr) chk("wr_hold", write_o, 1'b1);
      else       chk("rd_hold", read_o, 1'b1);
      @(posedge clk); #1;
      if (pat[i]) nb++;
    end
    resp_i  = 1'b0;
    burst_i = '0;
    @(negedge clk);
    chk("resp_lat", resp_o, 1'b1);
    chk("done_quiet", read_o | write_o, 1'b0);
    @(posedge clk); #1;
    read_i  = 1'b0;
    write_i = 1'b0;
  endtask

  localparam logic [255:0] RD_LINE = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
  localparam logic [255:0] WR_LINE = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
  localparam logic [255:0] B2B_LINE = {{16{4'h8}}, {16{4'h7}}, {16{4'h6}}, {16{4'h5}}};
  localparam logic [255:0] BOTH_LINE = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                        64'h0F0F_0F0F_F0F0_F0F0, 64'h5A5A_A5A5_3C3C_C3C3};

  initial begin
    rst       = 1'b1;
    read_i    = 1'b1;
    write_i   = 1'b0;
    resp_i    = 1'b0;
    burst_i   = '0;
    line_i    = '0;
    address_i = 32'h0000_1234;

    // Reset held two cycles with a read pending
    repeat (2) @(posedge clk);
    #1;
    chk("rst_line_o", line_o, '0);
    chk("rst_addr_o", address_o, '0);
    chk("rst_burst_o", burst_o, '0);
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_resp_o", resp_o, 1'b0);
    begin
      req_t r;
      r.is_wr = 1'b0;
      r.addr  = 32'h0000_1220;
      exp_req.push_back(r);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_rd", read_o, 1'b0);
    @(posedge clk); #1;

    // Two beats then reset mid-burst: abandoned, no response
    resp_i  = 1'b1;
    burst_i = {16{4'h1}};
    @(negedge clk);
    chk("mid_rd_hold", read_o, 1'b1);
    @(posedge clk); #1;
    burst_i = {16{4'h2}};
    @(posedge clk); #1;
    resp_i  = 1'b0;
    burst_i = '0;
    rst     = 1'b1;
    @(posedge clk); #1;
    rst    = 1'b0;
    read_i = 1'b0;
    @(negedge clk);
    chk("mid_rst_read_o", read_o, 1'b0);
    chk("mid_rst_resp_o", resp_o, 1'b0);
    chk("mid_rst_line_o", line_o, '0);
    repeat (3) @(posedge clk);
    #1;

    // Read without bubbles; then the same read with bubbles 1,0,0,1,1,0,1
    do_accept(1'b0, 1'b0, 32'h0000_1234, 32'h0000_1220, '0);
    do_beats(1'b0, RD_LINE, 8'h0F, 4);
    do_accept(1'b0, 1'b0, 32'h0000_1234, 32'h0000_1220, '0);
    do_beats(1'b0, RD_LINE, 8'h59, 7);

    // Writeback with a bubble, immediately followed by a fill
    do_accept(1'b1, 1'b0, 32'h0000_5678, 32'h0000_5660, WR_LINE);
    do_beats(1'b1, WR_LINE, 8'h1B, 5);
    do_accept(1'b0, 1'b0, 32'h0000_9ABF, 32'h0000_9AA0, '0);
    do_beats(1'b0, B2B_LINE, 8'h0F, 4);

    // Simultaneous read and write requests resolve to a write
    do_accept(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFE0, BOTH_LINE);
    do_beats(1'b1, BOTH_LINE, 8'h0F, 4);

    repeat (4) @(posedge clk);
    #1;
    chk("fill_line_held", line_o, B2B_LINE);
    chk("resp_pulses", resp_cnt, exp_pulses);
    chk("req_q_empty", exp_req.size(), 0);
    chk("rsp_q_empty", exp_rsp.size(), 0);
    chk("wbeat_q_empty", exp_wbeat.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits directly downstream of the L1 cache controller/datapath.
- Converts the cache's single-shot 256-bit line request (pmem_read/pmem_write/pmem_resp) into a 4-beat 64-bit burst transaction on physical memory.
- On reads, assembles beats into a full line.
- On writebacks, serialises the latched line into beats and returns one cache-side response per line.

Parameters:
- LINE_W, 256, cache line width in bits.
- BURST_W, 64, memory beat width in bits; BEATS = LINE_W/BURST_W (4); LINE_W must be an integer multiple of BURST_W.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous active-high reset.
- line_i  in  LINE_W  writeback line from cache datapath.
- line_o  out  LINE_W  assembled fill line to cache datapath.
- address_i  in  ADDR_W  cache-side line address.
- read_i  in  1  cache line read request (level, held until resp_o).
- write_i  in  1  cache line write request (level, held until resp_o).
- resp_o  out  1  one-cycle line-complete pulse to cache controller.
- burst_i  in  BURST_W  read beat from memory.
- burst_o  out  BURST_W  write beat to memory.
- address_o  out  ADDR_W  line-aligned burst address.
- read_o  out  1  memory burst read request.
- write_o  out  1  memory burst write request.
- resp_i  in  1  memory beat handshake; one beat transferred per cycle it is high.

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE, beat counter=0.
  - line_o=0, burst_o=0, address_o=0, read_o=0, write_o=0, resp_o=0.
  - Reset mid-burst abandons the transaction: no resp_o pulse, next cycle is IDLE.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - write_i=1: latch line_i into the write buffer and latch address_i; go to WR.
  - Else read_i=1: latch address_i; go to RD.
  - Both high: write wins.
  - resp_i and burst_i are ignored.
- Address latching: address_o = {address_i[ADDR_W-1:5], 5'b0}. The low log2(LINE_W/8) bits are forced to 0. address_o holds until the next accept.
- RD:
  - read_o=1 for the whole state.
  - Each cycle with resp_i=1: burst_i is stored into line_o[BURST_W*cnt +: BURST_W] (beat 0 = least-significant 64 bits); cnt increments.
  - Cycles with resp_i=0 are bubbles: no capture, cnt holds, read_o stays high.
  - After the capture with cnt==BEATS-1: cnt←0, go to DONE.
- WR:
  - write_o=1 for the whole state.
  - burst_o = buffer[BURST_W*cnt +: BURST_W], driven combinationally from cnt.
  - Each resp_i=1 advances cnt (beat accepted); bubbles hold cnt.
  - After the accept with cnt==BEATS-1: cnt←0, go to DONE.
- DONE:
  - resp_o=1 for exactly this one cycle; read_o=write_o=0.
  - Unconditionally go to IDLE.
  - A request still high in DONE is not re-accepted.
- Outputs read_o, write_o, resp_o and burst_o are decoded from state and cnt (Moore).
- line_o holds the last assembled line until the next RD beat 0 overwrites it.
- Latency: request sampled in IDLE at cycle 0 → read_o/write_o high from cycle 1. With zero-bubble memory, beats occur in cycles 1–4 and resp_o fires in cycle 5. Each bubble adds one cycle.
- Back-to-back: the cache's writeback→fill sequence presents read_i in the cycle after resp_o. The adaptor is in IDLE then and accepts it, so there are no dead cycles beyond DONE.
- The write buffer is a private copy. line_i changes after acceptance must not affect burst_o.
- Counter width: clog2(BEATS). Wrap to 0 only via the last-beat rule; no free-running wrap.

Test Plan:
- Reset: hold rst 2 cycles with read_i=1 → all outputs 0, state IDLE, no read_o in the cycle after rst drops until the request is re-sampled (read_o high on the following cycle).
- Read, no bubbles:
  - Stimulus: address_i=0x0000_1234, read_i=1; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on cycles 1–4.
  - Required: address_o=0x0000_1220; read_o high cycles 1–4; resp_o only in cycle 5; line_o={0x44..44,0x33..33,0x22..22,0x11..11}.
- Read with bubbles:
  - Stimulus: same read with resp_i pattern 1,0,0,1,1,0,1.
  - Required: read_o held high throughout; exactly 4 captures, in order; resp_o one cycle after the 4th beat; line_o identical to the no-bubble case.
- Write:
  - Stimulus: line_i=0xDDDD…_CCCC…_BBBB…_AAAA…, write_i=1; line_i changed to 0 after acceptance.
  - Required: burst_o sequence 0xAAAA…, 0xBBBB…, 0xCCCC…, 0xDDDD… on accepts; write_o deasserted in DONE; single resp_o pulse.
- Writeback then fill:
  - Stimulus: write_i until resp_o, then read_i the following cycle; additionally, read_i=write_i=1 in IDLE.
  - Required: write burst first, then read burst starting the cycle after resp_o; exactly 2 resp_o pulses; simultaneous request is treated as a write.
- Reset mid-burst:
  - Stimulus: assert rst after 2 read beats.
  - Required: next cycle read_o=0, resp_o never pulses, cnt=0. A subsequent read completes normally with 4 fresh beats.
